// File: rtl/control_unit_types_pkg.sv
// Control encodings: writeback source select and the memory-stage FSM states.
package control_unit_types_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_NPC  = 2'd2,
        WB_ALU3 = 2'd3
    } memtoreg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mmstate_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared across the pipeline stages.
package cpu_types_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int REG_WIDTH  = 5;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [REG_WIDTH-1:0]  regbits_t;

endpackage

// File: rtl/mm_llsc.sv
// Link register for LL/SC: set by a completed LL, cleared by any completed
// store to the linked word. sc_ok tells whether an SC at addr may proceed.
module mm_llsc
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ll,
    input  logic              rd_done,
    input  logic              wr_done,
    input  logic [WORD_W-1:0] addr,
    output logic              sc_ok
);

    logic [WORD_W-1:0] linkaddr;
    logic              linkvalid;

    assign sc_ok = linkvalid & (linkaddr == addr);

    // Link register: LL completion arms it, a store to the same word disarms it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            linkaddr  <= '0;
            linkvalid <= 1'b0;
        end else if (rd_done & ll) begin
            linkaddr  <= addr;
            linkvalid <= 1'b1;
        end else if (wr_done & (linkaddr == addr)) begin
            linkvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/mm_stage.sv
// Memory-access stage: issues the dcache request, holds it until dhit,
// stalls upstream meanwhile, and registers the MEM/WB values.
// Optional LL/SC support is compiled in with `define MM_LLSC_EN.
module mm_stage
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH,
    parameter int REG_W  = REG_WIDTH
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              flush,
    input  logic              dRENi,
    input  logic              dWENi,
    input  logic              RegWEN,
    input  logic [1:0]        MemtoReg,
    input  logic [REG_W-1:0]  rd,
    input  logic [WORD_W-1:0] ALUOut,
    input  logic [WORD_W-1:0] store,
    input  logic [WORD_W-1:0] npc,
    input  logic              halt,
`ifdef MM_LLSC_EN
    input  logic              ll,
    input  logic              sc,
`endif
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mm_busy,
    output logic              misalign,
    output logic              wb_RegWEN,
    output logic [REG_W-1:0]  wb_rd,
    output logic [WORD_W-1:0] wb_wdat,
    output logic              wb_halt,
    output logic              wb_valid
);

    mmstate_t          state, next_state;
    logic              halted;
    logic              flushed;
    logic [WORD_W-1:0] loadbuf;
    logic [WORD_W-1:0] aligned_addr;
    logic [WORD_W-1:0] wdat_sel;
    logic              wen_eff;
    logic              mem_req;
    logic              active;
    logic              advance;
    logic              kill;

    assign aligned_addr = {ALUOut[WORD_W-1:2], 2'b00};

`ifdef MM_LLSC_EN
    logic sc_ok;

    mm_llsc #(.WORD_W(WORD_W)) u_llsc (
        .CLK     (CLK),
        .nRST    (nRST),
        .ll      (ll),
        .rd_done (active & dhit & dRENi),
        .wr_done (active & dhit & wen_eff),
        .addr    (aligned_addr),
        .sc_ok   (sc_ok)
    );

    // A failing SC never reaches the cache.
    assign wen_eff = dWENi & (~sc | sc_ok);
`else
    assign wen_eff = dWENi;
`endif

    // Requests are gated by nRST so they drop the instant reset asserts,
    // even though the upstream latch may still be presenting a memory op.
    assign mem_req  = nRST & (dRENi | wen_eff) & ~halted;
    assign misalign = nRST & (dRENi | dWENi) & (ALUOut[1:0] != 2'b00);

    // Next-state logic; an access starts combinationally out of IDLE.
    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no
        // path leaves it unassigned and no latch is inferred.
        next_state = state;
        active     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req & ~flush) begin
                    active     = 1'b1;
                    next_state = dhit ? (ihit ? IDLE : DONE) : ACCESS;
                end
            end
            ACCESS: begin
                active = 1'b1;
                if (dhit) next_state = ihit ? IDLE : DONE;
            end
            DONE: begin
                if (ihit) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign dmemREN   = active & dRENi;
    assign dmemWEN   = active & wen_eff;
    assign dmemaddr  = active ? aligned_addr : '0;
    assign dmemstore = active ? store : '0;
    assign mm_busy   = active & ~dhit;
    assign advance   = ihit & ~mm_busy;
    assign kill      = flush | flushed;

    // Writeback data select; a same-cycle hit bypasses the load buffer.
    always_comb begin
        case (memtoreg_t'(MemtoReg))
            WB_MEM:  wdat_sel = (active & dhit) ? dmemload : loadbuf;
            WB_NPC:  wdat_sel = npc;
            default: wdat_sel = ALUOut;
        endcase
`ifdef MM_LLSC_EN
        // Only a successful SC ever reaches DONE, and the link is already
        // cleared by then, so DONE itself stands in for success.
        if (sc) wdat_sel = {{(WORD_W-1){1'b0}}, sc_ok | (state == DONE)};
`endif
    end

    // FSM state, load buffer, sticky halt and pending-flush flags.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!nRST) begin
            state   <= IDLE;
            loadbuf <= '0;
            halted  <= 1'b0;
            flushed <= 1'b0;
        end else begin
            state <= next_state;
            if (active & dhit) loadbuf <= dmemload;
            if (advance & ~kill & halt) halted <= 1'b1;
            if (advance)    flushed <= 1'b0;
            else if (flush) flushed <= 1'b1;
        end
    end

    // MEM/WB register: bubble while stalled or squashed, load on advance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_RegWEN <= 1'b0;
            wb_rd     <= '0;
            wb_wdat   <= '0;
            wb_halt   <= 1'b0;
            wb_valid  <= 1'b0;
        end else if (mm_busy | (advance & kill)) begin
            wb_RegWEN <= 1'b0;
            wb_halt   <= 1'b0;
            wb_valid  <= 1'b0;
        end else if (advance) begin
            wb_RegWEN <= RegWEN;
            wb_rd     <= rd;
            wb_wdat   <= wdat_sel;
            wb_halt   <= halt;
            wb_valid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mm_stage.sv
// Directed bench for mm_stage: reset, load/store timing, writeback select,
// flush, halt, reset mid-access and (when MM_LLSC_EN is defined) LL/SC.
module tb_mm_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, flush, dRENi, dWENi, RegWEN, halt, dhit;
    logic        ll, sc;
    logic [1:0]  MemtoReg;
    logic [4:0]  rd;
    logic [31:0] ALUOut, store, npc, dmemload;
    logic        dmemREN, dmemWEN, mm_busy, misalign;
    logic [31:0] dmemaddr, dmemstore, wb_wdat;
    logic        wb_RegWEN, wb_halt, wb_valid;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;
    int wr_hits = 0;

    mm_stage dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ihit      (ihit),
        .flush     (flush),
        .dRENi     (dRENi),
        .dWENi     (dWENi),
        .RegWEN    (RegWEN),
        .MemtoReg  (MemtoReg),
        .rd        (rd),
        .ALUOut    (ALUOut),
        .store     (store),
        .npc       (npc),
        .halt      (halt),
`ifdef MM_LLSC_EN
        .ll        (ll),
        .sc        (sc),
`endif
        .dhit      (dhit),
        .dmemload  (dmemload),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .mm_busy   (mm_busy),
        .misalign  (misalign),
        .wb_RegWEN (wb_RegWEN),
        .wb_rd     (wb_rd),
        .wb_wdat   (wb_wdat),
        .wb_halt   (wb_halt),
        .wb_valid  (wb_valid)
    );

    always #5 CLK = ~CLK;

    // Count completed write handshakes seen by the cache.
    always @(posedge CLK) if (dmemWEN & dhit) wr_hits <= wr_hits + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ihit = 0; flush = 0; dRENi = 0; dWENi = 0; RegWEN = 0; halt = 0;
        dhit = 0; ll = 0; sc = 0; MemtoReg = 2'd0; rd = '0;
        ALUOut = '0; store = '0; npc = '0; dmemload = '0;
    endtask

    task automatic set_lw(input logic [31:0] addr, input logic [4:0] dst);
        clear_inputs();
        dRENi = 1; RegWEN = 1; MemtoReg = 2'd1; rd = dst; ALUOut = addr; ihit = 1;
    endtask

    initial begin
        clear_inputs();
        nRST = 0;

        // 1. reset held with random inputs: everything stays at zero
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            {ihit, flush, dRENi, dWENi, RegWEN, halt, dhit} = 7'($urandom);
            MemtoReg = 2'($urandom); rd = 5'($urandom);
            ALUOut = $urandom; store = $urandom; npc = $urandom; dmemload = $urandom;
            #1;
            check("rst_ctl", {25'd0, dmemREN, dmemWEN, mm_busy, misalign, wb_RegWEN, wb_halt, wb_valid}, 32'd0);
            check("rst_addr", dmemaddr | dmemstore, 32'd0);
            check("rst_wb", wb_wdat | {27'd0, wb_rd}, 32'd0);
        end
        @(negedge CLK);
        clear_inputs();
        nRST = 1;
        @(negedge CLK);
        check("post_rst_ren", {31'd0, dmemREN}, 32'd0);
        check("post_rst_busy", {31'd0, mm_busy}, 32'd0);

        // 2. LW 0x104, three stall cycles then hit
        set_lw(32'h104, 5'd8);
        #1;
        check("lw_ren", {31'd0, dmemREN}, 32'd1);
        check("lw_addr", dmemaddr, 32'h104);
        check("lw_busy1", {31'd0, mm_busy}, 32'd1);
        @(negedge CLK);
        check("lw_busy2", {31'd0, mm_busy}, 32'd1);
        check("lw_bubble", {31'd0, wb_valid}, 32'd0);
        @(negedge CLK);
        check("lw_busy3", {31'd0, mm_busy}, 32'd1);
        @(negedge CLK);
        dhit = 1; dmemload = 32'hDEADBEEF;
        #1;
        check("lw_hit_busy", {31'd0, mm_busy}, 32'd0);
        @(negedge CLK);
        clear_inputs();
        check("lw_wdat", wb_wdat, 32'hDEADBEEF);
        check("lw_rd", {27'd0, wb_rd}, 32'd8);
        check("lw_regwen", {31'd0, wb_RegWEN}, 32'd1);
        check("lw_valid", {31'd0, wb_valid}, 32'd1);
        #1;
        check("lw_ren_drop", {31'd0, dmemREN}, 32'd0);

        // 3. SW to misaligned 0x206; hit without ihit, so DONE is visited
        @(negedge CLK);
        dWENi = 1; ALUOut = 32'h206; store = 32'h55; ihit = 0;
        #1;
        check("sw_wen", {31'd0, dmemWEN}, 32'd1);
        check("sw_addr", dmemaddr, 32'h204);
        check("sw_data", dmemstore, 32'h55);
        check("sw_misalign", {31'd0, misalign}, 32'd1);
        @(negedge CLK);
        dhit = 1;
        @(negedge CLK);
        dhit = 0;
        #1;
        check("sw_done_wen", {31'd0, dmemWEN}, 32'd0);
        check("sw_done_busy", {31'd0, mm_busy}, 32'd0);
        ihit = 1;
        @(negedge CLK);
        clear_inputs();
        check("sw_regwen", {31'd0, wb_RegWEN}, 32'd0);
        check("sw_valid", {31'd0, wb_valid}, 32'd1);
        check("sw_one_write", wr_hits, 32'd1);

        // 5. flush during ACCESS: request held until dhit, result discarded
        @(negedge CLK);
        set_lw(32'h80, 5'd3);
        @(negedge CLK);
        flush = 1;
        #1;
        check("fl_ren_held1", {31'd0, dmemREN}, 32'd1);
        @(negedge CLK);
        flush = 0;
        #1;
        check("fl_ren_held2", {31'd0, dmemREN}, 32'd1);
        @(negedge CLK);
        dhit = 1; dmemload = 32'h1234;
        @(negedge CLK);
        clear_inputs();
        check("fl_valid", {31'd0, wb_valid}, 32'd0);
        check("fl_regwen", {31'd0, wb_RegWEN}, 32'd0);
        // following ALU op is not affected by the earlier flush
        RegWEN = 1; rd = 5'd5; ALUOut = 32'h77; ihit = 1;
        @(negedge CLK);
        check("alu_wdat", wb_wdat, 32'h77);
        check("alu_valid", {31'd0, wb_valid}, 32'd1);
        // flush in IDLE: no request, bubble
        set_lw(32'h90, 5'd6);
        flush = 1;
        #1;
        check("fl_idle_ren", {31'd0, dmemREN}, 32'd0);
        @(negedge CLK);
        check("fl_idle_valid", {31'd0, wb_valid}, 32'd0);

        // single-cycle access: hit and ihit in the first cycle
        set_lw(32'h10, 5'd9);
        dhit = 1; dmemload = 32'hCAFEF00D;
        #1;
        check("fast_busy", {31'd0, mm_busy}, 32'd0);
        check("fast_ren", {31'd0, dmemREN}, 32'd1);
        @(negedge CLK);
        clear_inputs();
        check("fast_wdat", wb_wdat, 32'hCAFEF00D);
        check("fast_rd", {27'd0, wb_rd}, 32'd9);

        // reset asserted mid-access drops the request at once
        set_lw(32'h20, 5'd2);
        @(negedge CLK);
        check("rma_busy", {31'd0, mm_busy}, 32'd1);
        #2 nRST = 0;
        #1;
        check("rma_ren", {31'd0, dmemREN}, 32'd0);
        check("rma_busy0", {31'd0, mm_busy}, 32'd0);
        @(negedge CLK);
        clear_inputs();
        nRST = 1;

`ifdef MM_LLSC_EN
        // 6. LL then SC succeeds; second SC fails without a request
        @(negedge CLK);
        set_lw(32'h300, 5'd4);
        ll = 1; dhit = 1;
        @(negedge CLK);
        clear_inputs();
        sc = 1; dWENi = 1; ALUOut = 32'h300; store = 32'hAA; RegWEN = 1; rd = 5'd4; ihit = 1;
        #1;
        check("sc1_wen", {31'd0, dmemWEN}, 32'd1);
        @(negedge CLK);
        dhit = 1;
        @(negedge CLK);
        dhit = 0;
        check("sc1_wdat", wb_wdat, 32'd1);
        #1;
        check("sc2_wen", {31'd0, dmemWEN}, 32'd0);
        check("sc2_busy", {31'd0, mm_busy}, 32'd0);
        @(negedge CLK);
        check("sc2_wdat", wb_wdat, 32'd0);
        clear_inputs();
`endif

        // 4. JAL writes npc, then halt blocks later memory access
        @(negedge CLK);
        clear_inputs();
        MemtoReg = 2'd2; npc = 32'h40; RegWEN = 1; rd = 5'd31; ihit = 1;
        #1;
        check("jal_ren", {31'd0, dmemREN}, 32'd0);
        @(negedge CLK);
        check("jal_wdat", wb_wdat, 32'h40);
        check("jal_rd", {27'd0, wb_rd}, 32'd31);
        MemtoReg = 2'd0; RegWEN = 0; halt = 1;
        @(negedge CLK);
        check("halt_wb", {31'd0, wb_halt}, 32'd1);
        set_lw(32'h100, 5'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halted_ren", {31'd0, dmemREN}, 32'd0);
            check("halted_busy", {31'd0, mm_busy}, 32'd0);
            @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
